quan_psum_accum_requant: RTL and testbench

//  Downstream of the per-column deskew delay stage. Takes the realigned row of systolic-array column sums (one PE word per column).

---
 rtl/quan_psum_accum_requant_if.sv | 28 ++
 rtl/quan_psum_accum_requant.sv | 176 +++++++++++++++++
 tb/tb_quan_psum_accum_requant.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/quan_psum_accum_requant_if.sv
// Tile-row input and quantized-row output bundle for quan_psum_accum_requant.
// The upstream deskew stage drives through the master modport. The requant block uses the slave modport.
interface quan_psum_accum_requant_if #(
    parameter int column_num_in_sa = 16,
    parameter int pe_out_width     = 64,
    parameter int LANES            = 4 * column_num_in_sa
);
    logic [pe_out_width*column_num_in_sa-1:0] delay_sum_row;
    logic                                     sum_valid;
    logic                                     sum_first;
    logic                                     sum_last;
    logic                                     mode_18;
    logic [15:0]                              q_scale;
    logic [4:0]                               q_shift;
    logic [8*LANES-1:0]                       q_out;
    logic                                     q_valid;
    logic [1:0]                               err_flags;

    modport master (
        output delay_sum_row, sum_valid, sum_first, sum_last, mode_18, q_scale, q_shift,
        input  q_out, q_valid, err_flags
    );

    modport slave (
        input  delay_sum_row, sum_valid, sum_first, sum_last, mode_18, q_scale, q_shift,
        output q_out, q_valid, err_flags
    );
endinterface

// File: rtl/quan_psum_accum_requant.sv
// Per-lane partial-sum accumulation across input-channel tiles.
// Each finished lane then passes through a 2-stage requantizer (scale, round-shift, clamp) to int8.
module quan_psum_accum_requant #(
    parameter int column_num_in_sa = 16,
    parameter int pixel_width_88   = 24,
    parameter int pixel_width_18   = 16,
    parameter int pe_out_width     = 64,
    parameter int ACC_W            = 32,
    parameter int LANES            = 4 * column_num_in_sa
) (
    input logic                     clk,
    input logic                     rst_n,
    quan_psum_accum_requant_if.slave bus
);
    localparam int PROD_W = ACC_W + 16;
    localparam int MUL_W  = ACC_W + 17;
    localparam int R_W    = PROD_W + 1;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [R_W-1:0]   Q_MAX   = R_W'(127);
    localparam logic signed [R_W-1:0]   Q_MIN   = -R_W'(128);

    // Configuration captured at the first tile of an accumulation
    logic        cfg_mode;
    logic [15:0] cfg_scale;
    logic [4:0]  cfg_shift;

    logic                     open;
    logic [1:0]               err_r;
    logic signed [ACC_W-1:0]  acc     [LANES];
    logic signed [ACC_W-1:0]  lane_in [LANES];
    logic                     take_first;
    logic                     take_cont;
    logic                     unpack_mode;
    logic                     v1;

    logic                     v2;
    logic                     mode2;
    logic [4:0]               shift2;
    logic signed [PROD_W-1:0] prod      [LANES];
    logic signed [PROD_W-1:0] prod_next [LANES];

    logic [8*LANES-1:0]       q_next;
    logic [8*LANES-1:0]       q_out_r;
    logic                     q_valid_r;

    function automatic logic signed [ACC_W-1:0] sat_add(
        input logic signed [ACC_W-1:0] a,
        input logic signed [ACC_W-1:0] b
    );
        logic [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        if (s[ACC_W] != s[ACC_W-1])
            return s[ACC_W] ? ACC_MIN : ACC_MAX;
        return s[ACC_W-1:0];
    endfunction

    always_comb begin
        take_first  = bus.sum_valid & bus.sum_first;
        take_cont   = bus.sum_valid & ~bus.sum_first & open;
        // The first tile brings its own mode; later tiles follow the captured one
        unpack_mode = bus.sum_first ? bus.mode_18 : cfg_mode;
    end

    always_comb begin
        for (int unsigned c = 0; c < column_num_in_sa; c++) begin
            for (int unsigned j = 0; j < 4; j++) begin
                lane_in[4*c+j] = '0;
                if (unpack_mode)
                    lane_in[4*c+j] = ACC_W'($signed(
                        bus.delay_sum_row[c*pe_out_width + j*pixel_width_18 +: pixel_width_18]));
                else if (j < 2)
                    lane_in[4*c+j] = ACC_W'($signed(
                        bus.delay_sum_row[c*pe_out_width + j*pixel_width_88 +: pixel_width_88]));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            open      <= 1'b0;
            err_r     <= '0;
            v1        <= 1'b0;
            cfg_mode  <= 1'b0;
            cfg_scale <= '0;
            cfg_shift <= '0;
            for (int unsigned i = 0; i < LANES; i++)
                acc[i] <= '0;
        end else begin
            v1 <= (take_first | take_cont) & bus.sum_last;
            if (take_first) begin
                cfg_mode  <= bus.mode_18;
                cfg_scale <= bus.q_scale;
                cfg_shift <= bus.q_shift;
                open      <= ~bus.sum_last;
                if (open)
                    err_r[1] <= 1'b1;
                for (int unsigned i = 0; i < LANES; i++)
                    acc[i] <= lane_in[i];
            end else if (take_cont) begin
                open <= ~bus.sum_last;
                for (int unsigned i = 0; i < LANES; i++)
                    acc[i] <= sat_add(acc[i], lane_in[i]);
            end else if (bus.sum_valid) begin
                err_r[0] <= 1'b1;
            end
        end
    end

    always_comb begin
        logic signed [MUL_W-1:0] a_ext;
        logic signed [MUL_W-1:0] s_ext;
        logic signed [MUL_W-1:0] full;
        for (int unsigned i = 0; i < LANES; i++) begin
            a_ext        = MUL_W'(acc[i]);
            s_ext        = MUL_W'(cfg_scale);
            full         = a_ext * s_ext;
            prod_next[i] = full[PROD_W-1:0];
        end
    end

    // Mode and shift travel with the product, so a new tile that re-captures config cannot disturb it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v2     <= 1'b0;
            mode2  <= 1'b0;
            shift2 <= '0;
            for (int unsigned i = 0; i < LANES; i++)
                prod[i] <= '0;
        end else begin
            v2 <= v1;
            if (v1) begin
                mode2  <= cfg_mode;
                shift2 <= cfg_shift;
                for (int unsigned i = 0; i < LANES; i++)
                    prod[i] <= prod_next[i];
            end
        end
    end

    always_comb begin
        logic signed [R_W-1:0] ext;
        logic signed [R_W-1:0] rnd;
        logic signed [R_W-1:0] r;
        q_next = '0;
        rnd    = (shift2 == '0) ? '0 : (R_W'(1) << (shift2 - 5'd1));
        for (int unsigned i = 0; i < LANES; i++) begin
            ext = R_W'(prod[i]);
            r   = (ext + rnd) >>> shift2;
            if (r > Q_MAX)
                q_next[8*i +: 8] = 8'h7f;
            else if (r < Q_MIN)
                q_next[8*i +: 8] = 8'h80;
            else
                q_next[8*i +: 8] = r[7:0];
            if (!mode2 && (i % 4) >= 2)
                q_next[8*i +: 8] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_out_r   <= '0;
            q_valid_r <= 1'b0;
        end else begin
            q_valid_r <= v2;
            if (v2)
                q_out_r <= q_next;
        end
    end

    assign bus.q_out     = q_out_r;
    assign bus.q_valid   = q_valid_r;
    assign bus.err_flags = err_r;
endmodule

// File: tb/tb_quan_psum_accum_requant.sv
// Directed-vector bench for quan_psum_accum_requant.
// Expected rows are hand-computed from the accumulate/requant rules.
module tb_quan_psum_accum_requant;
    localparam int COLS  = 16;
    localparam int PE    = 64;
    localparam int LANES = 4 * COLS;
    localparam int ROW_W = PE * COLS;
    localparam int Q_W   = 8 * LANES;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    quan_psum_accum_requant_if #(
        .column_num_in_sa(COLS),
        .pe_out_width(PE),
        .LANES(LANES)
    ) bus ();

    quan_psum_accum_requant #(
        .column_num_in_sa(COLS),
        .pixel_width_88(24),
        .pixel_width_18(16),
        .pe_out_width(PE),
        .ACC_W(32),
        .LANES(LANES)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [Q_W-1:0] obs, input logic [Q_W-1:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
    endtask

    function automatic logic [ROW_W-1:0] row_all16(input logic [15:0] v);
        logic [ROW_W-1:0] r;
        for (int i = 0; i < LANES; i++)
            r[16*i +: 16] = v;
        return r;
    endfunction

    function automatic logic [ROW_W-1:0] row_lane0(input logic [15:0] v);
        logic [ROW_W-1:0] r;
        r = '0;
        r[15:0] = v;
        return r;
    endfunction

    function automatic logic [Q_W-1:0] exp_all(input logic [7:0] b);
        logic [Q_W-1:0] e;
        for (int i = 0; i < LANES; i++)
            e[8*i +: 8] = b;
        return e;
    endfunction

    function automatic logic [Q_W-1:0] exp_lane0(input logic [7:0] b);
        logic [Q_W-1:0] e;
        e = '0;
        e[7:0] = b;
        return e;
    endfunction

    task automatic send(input logic [ROW_W-1:0] row, input logic first, input logic last,
                        input logic m18, input logic [15:0] sc, input logic [4:0] sh);
        @(negedge clk);
        bus.delay_sum_row = row;
        bus.sum_valid     = 1'b1;
        bus.sum_first     = first;
        bus.sum_last      = last;
        bus.mode_18       = m18;
        bus.q_scale       = sc;
        bus.q_shift       = sh;
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.sum_valid = 1'b0;
        bus.sum_first = 1'b0;
        bus.sum_last  = 1'b0;
    endtask

    // Called right after the edge that accepted the last tile
    task automatic expect_result(input string tag, input logic [Q_W-1:0] exp);
        #1 check({tag, " qv@T"}, Q_W'(bus.q_valid), '0);
        idle();
        @(posedge clk); #1 check({tag, " qv@T+1"}, Q_W'(bus.q_valid), '0);
        @(posedge clk); #1 check({tag, " qv@T+2"}, Q_W'(bus.q_valid), Q_W'(1));
        check({tag, " q_out"}, bus.q_out, exp);
        @(posedge clk); #1 check({tag, " qv@T+3"}, Q_W'(bus.q_valid), '0);
        check({tag, " q_out hold"}, bus.q_out, exp);
    endtask

    task automatic watch_no_valid(input string tag, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk); #1 seen = seen | bus.q_valid;
        end
        check(tag, Q_W'(seen), '0);
    endtask

    initial begin
        logic [ROW_W-1:0] r4;

        rst_n = 1'b0;
        bus.delay_sum_row = '0;
        bus.sum_valid = 1'b0;
        bus.sum_first = 1'b0;
        bus.sum_last  = 1'b0;
        bus.mode_18   = 1'b1;
        bus.q_scale   = 16'd1;
        bus.q_shift   = 5'd0;

        // T1 reset
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("t1 q_out", bus.q_out, '0);
        check("t1 q_valid", Q_W'(bus.q_valid), '0);
        check("t1 err", Q_W'(bus.err_flags), '0);

        // T2 single tile, all lanes 100
        send(row_all16(16'd100), 1'b1, 1'b1, 1'b1, 16'd1, 5'd0);
        expect_result("t2", exp_all(8'h64));

        // T3 three tiles; config changes on later tiles must be ignored
        send(row_lane0(16'd1000), 1'b1, 1'b0, 1'b1, 16'd3, 5'd4);
        send(row_lane0(16'(-300)), 1'b0, 1'b0, 1'b0, 16'd50, 5'd0);
        send(row_lane0(16'd50), 1'b0, 1'b1, 1'b0, 16'd50, 5'd0);
        expect_result("t3", exp_lane0(8'h7f));
        check("t3 err", Q_W'(bus.err_flags), '0);

        // T4 mode_18=0, lanes 0 and 1 at -2^23 for 300 tiles -> -2^31 -> -1
        r4 = '0;
        r4[63:0] = {16'h8000, 24'h800000, 24'h800000};
        for (int k = 0; k < 300; k++)
            send(r4, k == 0, k == 299, 1'b0, 16'd1, 5'd31);
        expect_result("t4", {{(Q_W-16){1'b0}}, 16'hffff});

        // T5 orphan tile, then restart mid-accumulation
        idle();
        send(row_lane0(16'd5), 1'b0, 1'b1, 1'b1, 16'd1, 5'd0);
        #1 check("t5 err orphan", Q_W'(bus.err_flags), Q_W'(2'b01));
        idle();
        watch_no_valid("t5 orphan no qv", 4);
        send(row_lane0(16'd7), 1'b1, 1'b0, 1'b1, 16'd1, 5'd0);
        send(row_lane0(16'd10), 1'b1, 1'b0, 1'b1, 16'd1, 5'd0);
        #1 check("t5 err restart", Q_W'(bus.err_flags), Q_W'(2'b11));
        send(row_lane0(16'd20), 1'b0, 1'b1, 1'b1, 16'd1, 5'd0);
        expect_result("t5", exp_lane0(8'd30));

        // T6 back-to-back single-tile rows
        for (int i = 1; i <= 5; i++) begin
            send(row_lane0(16'(i)), 1'b1, 1'b1, 1'b1, 16'd1, 5'd0);
            #1;
            if (i >= 3) begin
                check($sformatf("t6 qv%0d", i - 2), Q_W'(bus.q_valid), Q_W'(1));
                check($sformatf("t6 lane0 #%0d", i - 2), bus.q_out, exp_lane0(8'(i - 2)));
            end
        end
        idle();
        @(posedge clk); #1 check("t6 qv4", Q_W'(bus.q_valid), Q_W'(1));
        check("t6 lane0 #4", bus.q_out, exp_lane0(8'd4));
        @(posedge clk); #1 check("t6 qv5", Q_W'(bus.q_valid), Q_W'(1));
        check("t6 lane0 #5", bus.q_out, exp_lane0(8'd5));
        @(posedge clk); #1 check("t6 qv end", Q_W'(bus.q_valid), '0);

        // T6b reset during the second back-to-back cycle
        send(row_lane0(16'd1), 1'b1, 1'b1, 1'b1, 16'd1, 5'd0);
        @(negedge clk);
        rst_n = 1'b0;
        bus.delay_sum_row = row_lane0(16'd2);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus.sum_valid = 1'b0;
        bus.sum_first = 1'b0;
        bus.sum_last  = 1'b0;
        watch_no_valid("t6b no qv", 6);
        check("t6b q_out", bus.q_out, '0);
        check("t6b err", Q_W'(bus.err_flags), '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
